// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register: takes a WIDTH-bit word over a valid/ready
// handshake and drives it one bit per clock with a qualifying valid flag and a done pulse.
module piso_shift_register #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             data,
    output logic             data_valid,
    output logic             done,
    output logic             dbg_state
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] bit_idx;
    logic             last;
    logic             accept;

    // Handshake: a word transfers on a rising edge where load_valid and load_ready are both 1;
    // load_valid without load_ready is ignored, and load_data is only sampled on that edge.
    assign last       = (state == SHIFT) && (bit_idx == LAST);
    assign load_ready = rst & ((state == IDLE) | last);
    assign accept     = load_valid & load_ready;
    assign dbg_state  = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_idx    <= '0;
            data       <= 1'b0;
            data_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                state      <= SHIFT;
                bit_idx    <= '0;
                data_valid <= 1'b1;
                // The first bit goes straight to the line; sreg keeps the rest, aligned to the send end.
                if (MSB_FIRST) begin
                    data <= load_data[WIDTH-1];
                    sreg <= load_data << 1;
                end else begin
                    data <= load_data[0];
                    sreg <= load_data >> 1;
                end
            end else if (last) begin
                state      <= IDLE;
                sreg       <= '0;
                data       <= 1'b0;
                data_valid <= 1'b0;
            end else if (state == SHIFT) begin
                bit_idx <= bit_idx + 1'b1;
                if (MSB_FIRST) begin
                    data <= sreg[WIDTH-1];
                    sreg <= sreg << 1;
                end else begin
                    data <= sreg[0];
                    sreg <= sreg >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: MSB-first, LSB-first and WIDTH=1 instances share one stimulus,
// each checked every cycle against a word-plus-bit-count model, plus literal stream checks.
module tb_piso_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [3:0] load_data;

    logic [2:0] dut_ready;
    logic [2:0] dut_data;
    logic [2:0] dut_valid;
    logic [2:0] dut_done;
    logic [2:0] dut_dbg;

    int checks = 0;
    int errors = 0;
    bit stim_done = 1'b0;

    // Model: per instance, the word in flight and which bit of it is on the line.
    int         w_a[3]   = '{4, 4, 1};
    bit         msb_a[3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] m_word[3];
    int         m_sent[3];
    bit         m_active[3];
    bit         m_done[3];

    always #5 clk = ~clk;

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(dut_ready[0]), .data(dut_data[0]), .data_valid(dut_valid[0]),
        .done(dut_done[0]), .dbg_state(dut_dbg[0])
    );

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(dut_ready[1]), .data(dut_data[1]), .data_valid(dut_valid[1]),
        .done(dut_done[1]), .dbg_state(dut_dbg[1])
    );

    piso_shift_register #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data[0:0]),
        .load_ready(dut_ready[2]), .data(dut_data[2]), .data_valid(dut_valid[2]),
        .done(dut_done[2]), .dbg_state(dut_dbg[2])
    );

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_word[k]   = '0;
            m_sent[k]   = 0;
            m_active[k] = 1'b0;
            m_done[k]   = 1'b0;
        end
    end

    always @(posedge clk) begin : model
        bit was_last;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                m_active[k] = 1'b0;
                m_sent[k]   = 0;
                m_done[k]   = 1'b0;
            end else begin
                was_last = m_active[k] && (m_sent[k] == w_a[k] - 1);
                if (load_valid && (!m_active[k] || was_last)) begin
                    m_word[k]   = load_data;
                    m_sent[k]   = 0;
                    m_active[k] = 1'b1;
                end else if (m_active[k]) begin
                    if (was_last) m_active[k] = 1'b0;
                    else          m_sent[k]   = m_sent[k] + 1;
                end
                m_done[k] = was_last;
            end
        end
    end

    function automatic logic model_bit(int k);
        int pos;
        pos = msb_a[k] ? (w_a[k] - 1 - m_sent[k]) : m_sent[k];
        return m_word[k][pos];
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic exp_ready;
        for (int k = 0; k < 3; k++) begin
            exp_ready = rst && (!m_active[k] || (m_sent[k] == w_a[k] - 1));
            check("model_valid", k, dut_valid[k], m_active[k]);
            check("model_data",  k, dut_data[k],  m_active[k] ? model_bit(k) : 1'b0);
            check("model_done",  k, dut_done[k],  m_done[k]);
            check("model_ready", k, dut_ready[k], exp_ready);
            check("model_state", k, dut_dbg[k],   m_active[k]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input logic [3:0] v);
        load_valid = 1'b1;
        load_data  = v;
        cycle();
        load_valid = 1'b0;
        load_data  = ~v;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("lit_msb_data", 0, dut_data[0], v[3-i]);
            check("lit_lsb_data", 1, dut_data[1], v[i]);
            check("lit_valid", 0, dut_valid[0], 1'b1);
            check("lit_ready", 0, dut_ready[0], (i == 3));
            check("lit_done", 0, dut_done[0], 1'b0);
            cycle();
        end
        #2;
        check("lit_done_end", 0, dut_done[0], 1'b1);
        check("lit_done_end", 1, dut_done[1], 1'b1);
        check("lit_valid_end", 0, dut_valid[0], 1'b0);
        cycle();
    endtask

    task automatic run_b2b(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] s;
        s = {a, b};
        load_valid = 1'b1;
        load_data  = a;
        cycle();
        load_data = b;
        for (int i = 0; i < 8; i++) begin
            #2;
            check("lit_b2b_data", 0, dut_data[0], s[7-i]);
            check("lit_b2b_valid", 0, dut_valid[0], 1'b1);
            check("lit_b2b_done", 0, dut_done[0], (i == 4));
            check("lit_b2b_ready", 0, dut_ready[0], (i == 3) || (i == 7));
            cycle();
            if (i == 3) load_valid = 1'b0;
        end
        #2;
        check("lit_b2b_done_end", 0, dut_done[0], 1'b1);
        check("lit_b2b_valid_end", 0, dut_valid[0], 1'b0);
        cycle();
    endtask

    task automatic stimulus();
        // Reset held for two edges with a pending request.
        rst        = 1'b0;
        load_valid = 1'b1;
        load_data  = 4'b1111;
        cycle();
        cycle();
        #2;
        for (int k = 0; k < 3; k++) begin
            check("lit_rst_data", k, dut_data[k], 1'b0);
            check("lit_rst_valid", k, dut_valid[k], 1'b0);
            check("lit_rst_done", k, dut_done[k], 1'b0);
            check("lit_rst_ready", k, dut_ready[k], 1'b0);
        end
        load_valid = 1'b0;
        rst        = 1'b1;
        #1;
        check("lit_ready_after_rst", 0, dut_ready[0], 1'b1);
        check("lit_ready_after_rst", 2, dut_ready[2], 1'b1);
        cycle();

        run_single(4'b1011);
        run_b2b(4'b1100, 4'b0011);
        run_b2b(4'b1010, 4'b0101);
        cycle();

        // Abort a frame with reset during its second bit.
        load_valid = 1'b1;
        load_data  = 4'b1111;
        cycle();
        load_valid = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        #2;
        check("lit_abort_data", 0, dut_data[0], 1'b0);
        check("lit_abort_valid", 0, dut_valid[0], 1'b0);
        check("lit_abort_done", 0, dut_done[0], 1'b0);
        check("lit_abort_ready", 0, dut_ready[0], 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            #2;
            check("lit_abort_no_done", 0, dut_done[0], 1'b0);
            check("lit_abort_idle", 0, dut_valid[0], 1'b0);
        end
        cycle();
        run_single(4'b0110);
        run_single(4'b1001);
        cycle();
        stim_done = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        fork
            begin
                @(posedge clk);
                while (!stim_done) begin
                    @(negedge clk);
                    if (!stim_done) compare_all();
                end
            end
            stimulus();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
